// File: rtl/decode_pipe.sv
// decode_pipe: registered MIPS decode stage between fetch and execute.
// A combinational decoder feeds a two-slot holding structure (output register
// plus one skid register). The skid catches the single instruction that can
// arrive in the cycle when execute stalls, so nothing is dropped or duplicated.
module decode_pipe #(
    parameter int PC_WIDTH      = 32,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         insn,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5:0]          opcode_out,
    output logic [4:0]          rs_out,
    output logic [4:0]          rt_out,
    output logic [4:0]          rd_out,
    output logic [4:0]          sa_out,
    output logic [5:0]          func_out,
    output logic [31:0]         imm_out,
    output logic [PC_WIDTH-1:0] target_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [1:0]          itype_out,
    output logic                illegal_out
);

    localparam bit MULDIV_EN = (ENABLE_MULDIV != 0);

    typedef struct packed {
        logic [5:0]          opcode;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [4:0]          sa;
        logic [5:0]          func;
        logic [31:0]         imm;
        logic [PC_WIDTH-1:0] target;
        logic [PC_WIDTH-1:0] pc;
        logic [1:0]          itype;
        logic                illegal;
    } bundle_t;

    // How the 16-bit immediate is widened for I-type instructions.
    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2
    } imm_mode_t;

    logic [5:0]          op;
    logic [5:0]          fn;
    logic [31:0]         sext_imm;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;

    logic                r_legal;
    logic                r_muldiv_op;
    logic                is_i;
    logic                is_branch;
    logic                is_jump;
    imm_mode_t           imm_mode;

    bundle_t             dec;
    bundle_t             out_reg;
    bundle_t             skid_reg;
    logic                skid_valid;
    logic                transfer_in;

    assign op            = insn[31:26];
    assign fn            = insn[5:0];
    assign sext_imm      = {{16{insn[15]}}, insn[15:0]};
    assign pc_plus4      = pc + PC_WIDTH'(4);
    assign branch_target = pc_plus4 + PC_WIDTH'(sext_imm << 2);
    assign jump_target   = {pc_plus4[PC_WIDTH-1:28], insn[25:0], 2'b00};

    // Classify the opcode/func into R, I (with immediate style), branch, jump or illegal.
    always_comb begin
        r_legal     = 1'b0;
        r_muldiv_op = 1'b0;
        is_i        = 1'b0;
        is_branch   = 1'b0;
        is_jump     = 1'b0;
        imm_mode    = IMM_SIGN;
        case (op)
            6'b000000: begin
                r_muldiv_op = fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011};
                r_legal = (fn inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                      6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                      6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                      6'b000011, 6'b000100, 6'b000110, 6'b000111,
                                      6'b001000, 6'b001001})
                       || (MULDIV_EN && (fn inside {6'b011000, 6'b011001, 6'b011010,
                                                    6'b011011, 6'b010000, 6'b010010}));
            end
            6'b001001, 6'b001010, 6'b001011,
            6'b100011, 6'b101011, 6'b100000, 6'b101000, 6'b100100: begin
                is_i = 1'b1;
            end
            6'b001101, 6'b001110: begin
                is_i     = 1'b1;
                imm_mode = IMM_ZERO;
            end
            6'b001111: begin
                is_i     = 1'b1;
                imm_mode = IMM_UPPER;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                is_i      = 1'b1;
                is_branch = 1'b1;
            end
            6'b000001: begin
                is_i      = (insn[20:17] == 4'b0000);
                is_branch = (insn[20:17] == 4'b0000);
            end
            6'b000010, 6'b000011: begin
                is_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Build the decoded bundle; illegal words keep the raw R-type field layout.
    always_comb begin
        dec         = '0;
        dec.opcode  = op;
        dec.rs      = insn[25:21];
        dec.rt      = insn[20:16];
        dec.rd      = insn[15:11];
        dec.sa      = insn[10:6];
        dec.func    = fn;
        dec.pc      = pc;
        dec.itype   = 2'd3;
        dec.illegal = 1'b1;
        if (r_legal) begin
            dec.itype   = 2'd0;
            dec.illegal = 1'b0;
            if (r_muldiv_op) begin
                dec.rd = '0;
                dec.sa = '0;
            end
        end else if (is_i) begin
            dec.itype   = 2'd1;
            dec.illegal = 1'b0;
            dec.rd      = '0;
            dec.sa      = '0;
            dec.func    = '0;
            case (imm_mode)
                IMM_ZERO:  dec.imm = {16'h0000, insn[15:0]};
                IMM_UPPER: dec.imm = {insn[15:0], 16'h0000};
                default:   dec.imm = sext_imm;
            endcase
            if (is_branch) begin
                dec.target = branch_target;
            end
        end else if (is_jump) begin
            dec.itype   = 2'd2;
            dec.illegal = 1'b0;
            dec.rs      = '0;
            dec.rt      = '0;
            dec.rd      = '0;
            dec.sa      = '0;
            dec.func    = '0;
            dec.target  = jump_target;
        end
    end

    assign in_ready    = ~skid_valid;
    assign transfer_in = in_valid & in_ready;

    // Output/skid slot management: skid always drains first, flush empties both slots.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_reg    <= '0;
            skid_reg   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_reg    <= skid_reg;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (transfer_in) begin
                out_reg   <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (transfer_in) begin
            skid_reg   <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign opcode_out  = out_reg.opcode;
    assign rs_out      = out_reg.rs;
    assign rt_out      = out_reg.rt;
    assign rd_out      = out_reg.rd;
    assign sa_out      = out_reg.sa;
    assign func_out    = out_reg.func;
    assign imm_out     = out_reg.imm;
    assign target_out  = out_reg.target;
    assign pc_out      = out_reg.pc;
    assign itype_out   = out_reg.itype;
    assign illegal_out = out_reg.illegal;

endmodule
